// File: rtl/rgb_frame_reader_pkg.sv
// rtl/rgb_frame_reader_pkg.sv - shared geometry, sample width, FSM states and luma coefficients
package rgb_frame_reader_pkg;

  localparam int DW         = 8;
  localparam int IMG_W_LOG2 = 7;
  localparam int IMG_H_LOG2 = 7;
  localparam int ADDR_W     = IMG_H_LOG2 + IMG_W_LOG2;

  localparam int unsigned LUMA_R = 77;
  localparam int unsigned LUMA_G = 150;
  localparam int unsigned LUMA_B = 29;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/rgb_frame_reader_skid_fifo.sv
// rtl/rgb_frame_reader_skid_fifo.sv - rgb_skid_fifo: 2-entry payload FIFO absorbing plane read latency under backpressure
module rgb_skid_fifo #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem0, mem1;
  logic             wr_ptr, rd_ptr;
  logic             do_pop;

  assign do_pop   = pop && (count != 2'd0);
  assign valid    = (count != 2'd0);
  assign pop_data = rd_ptr ? mem1 : mem0;

  // A push at full occupancy is only legal alongside a pop; the slot it overwrites is the one leaving.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) mem1 <= push_data;
        else        mem0 <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rgb_frame_reader.sv
// rtl/rgb_frame_reader.sv - raster read-back of R/G/B planes onto a valid/ready pixel stream
// Optional luma output out_y when RGB_FRAME_READER_GRAY_EN is defined.
module rgb_frame_reader #(
  parameter int IMG_W_LOG2 = rgb_frame_reader_pkg::IMG_W_LOG2,
  parameter int IMG_H_LOG2 = rgb_frame_reader_pkg::IMG_H_LOG2,
  parameter int DW         = rgb_frame_reader_pkg::DW
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic [IMG_H_LOG2+IMG_W_LOG2-1:0] addr_r,
  output logic [IMG_H_LOG2+IMG_W_LOG2-1:0] addr_g,
  output logic [IMG_H_LOG2+IMG_W_LOG2-1:0] addr_b,
  input  logic [DW-1:0]                  rdata_r,
  input  logic [DW-1:0]                  rdata_g,
  input  logic [DW-1:0]                  rdata_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DW-1:0]                  out_r,
  output logic [DW-1:0]                  out_g,
  output logic [DW-1:0]                  out_b,
  output logic                           out_eol,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done
`ifdef RGB_FRAME_READER_GRAY_EN
  ,
  output logic [DW-1:0]                  out_y
`endif
);

  import rgb_frame_reader_pkg::*;

  localparam int AW = IMG_H_LOG2 + IMG_W_LOG2;
  localparam logic [AW-1:0] LAST_ADDR = '1;
`ifdef RGB_FRAME_READER_GRAY_EN
  localparam int PW = 4*DW + 2;
`else
  localparam int PW = 3*DW + 2;
`endif

  state_t        state, state_next;
  logic [AW-1:0] p, tag;
  logic          inflight;
  logic          issue, pop, fifo_valid;
  logic [1:0]    count;
  logic          eol_in, last_in;
  logic [PW-1:0] push_data, pop_data;

  assign pop = fifo_valid && out_ready;

  // Credit check: entries held plus the read in flight, less the one leaving, must leave room.
  assign issue = (state == STREAM) &&
                 (({1'b0, count} + {2'b00, inflight} - {2'b00, pop}) < 3'd2);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = STREAM;
      STREAM:  if (issue && (p == LAST_ADDR)) state_next = DRAIN;
      DRAIN:   if ((count == 2'd0) && !inflight) state_next = FINISH;
      FINISH:  if (start) state_next = STREAM;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      p        <= '0;
      tag      <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      if (issue) tag <= p;
      if (((state == IDLE) || (state == FINISH)) && start) p <= '0;
      else if (issue && (p != LAST_ADDR)) p <= p + 1'b1;
    end
  end

  assign addr_r = p;
  assign addr_g = p;
  assign addr_b = p;

  assign eol_in  = &tag[IMG_W_LOG2-1:0];
  assign last_in = &tag;

`ifdef RGB_FRAME_READER_GRAY_EN
  logic [DW+8:0] luma_acc;
  logic [DW-1:0] y_in;
  assign luma_acc = (DW+9)'(LUMA_R) * (DW+9)'(rdata_r) +
                    (DW+9)'(LUMA_G) * (DW+9)'(rdata_g) +
                    (DW+9)'(LUMA_B) * (DW+9)'(rdata_b);
  assign y_in      = DW'(luma_acc >> 8);
  assign push_data = {rdata_r, rdata_g, rdata_b, eol_in, last_in, y_in};
  assign {out_r, out_g, out_b, out_eol, out_last, out_y} = pop_data;
`else
  assign push_data = {rdata_r, rdata_g, rdata_b, eol_in, last_in};
  assign {out_r, out_g, out_b, out_eol, out_last} = pop_data;
`endif

  rgb_skid_fifo #(
    .WIDTH(PW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight),
    .push_data(push_data),
    .pop      (pop),
    .pop_data (pop_data),
    .valid    (fifo_valid),
    .count    (count)
  );

  assign out_valid = fifo_valid;
  assign busy      = (state == STREAM) || (state == DRAIN);
  assign done      = (state == FINISH);

endmodule
